// File: rtl/fp_vector_checker.sv
// Vector sequencer for multi-cycle FP units with start/done handshake.
// Fetches vectors, drives the unit, checks result/flags and keeps stats.
module fp_vector_checker #(
  parameter int WIDTH        = 64,
  parameter int FLAGW        = 5,
  parameter int AW           = 16,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 64,
  parameter int CW           = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     abort,
  input  logic                     cmp_flags,
  output logic [AW-1:0]            vec_addr,
  input  logic [3*WIDTH+FLAGW-1:0] vec_data,
  input  logic                     vec_valid,
  output logic [WIDTH-1:0]         dut_op1,
  output logic [WIDTH-1:0]         dut_op2,
  output logic                     dut_start,
  input  logic [WIDTH-1:0]         dut_result,
  input  logic [FLAGW-1:0]         dut_flags,
  input  logic                     dut_done,
  output logic                     busy,
  output logic                     finished,
  output logic                     mismatch,
  output logic [CW-1:0]            vec_count,
  output logic [CW-1:0]            err_count,
  output logic [CW-1:0]            tmo_count,
  output logic [AW-1:0]            first_err_addr,
  output logic                     first_err_valid
);

  localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START,
    S_WAIT, S_CHECK, S_NEXT, S_DONE
  } state_t;

  state_t           state_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] op1_q, op2_q, exp_q;
  logic [FLAGW-1:0] fexp_q;
  logic [SW-1:0]    scnt_q;
  logic [TW-1:0]    tmr_q;
  logic             tmo_q;
  logic [CW-1:0]    vcnt_q, ecnt_q, tcnt_q;
  logic [AW-1:0]    fea_q;
  logic             fev_q;
  logic             fail;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  assign fail = tmo_q | (dut_result != exp_q)
              | (cmp_flags & (dut_flags != fexp_q));

  assign vec_addr        = addr_q;
  assign dut_op1         = op1_q;
  assign dut_op2         = op2_q;
  assign dut_start       = (state_q == S_START);
  assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);
  assign finished        = (state_q == S_DONE);
  assign mismatch        = (state_q == S_CHECK) && fail;
  assign vec_count       = vcnt_q;
  assign err_count       = ecnt_q;
  assign tmo_count       = tcnt_q;
  assign first_err_addr  = fea_q;
  assign first_err_valid = fev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      exp_q   <= '0;
      fexp_q  <= '0;
      scnt_q  <= '0;
      tmr_q   <= '0;
      tmo_q   <= 1'b0;
      vcnt_q  <= '0;
      ecnt_q  <= '0;
      tcnt_q  <= '0;
      fea_q   <= '0;
      fev_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (run) begin
          vcnt_q  <= '0;
          ecnt_q  <= '0;
          tcnt_q  <= '0;
          fev_q   <= 1'b0;
          addr_q  <= '0;
          state_q <= S_FETCH;
        end
        S_FETCH: state_q <= abort ? S_DONE : S_LOAD;
        S_LOAD: begin
          if (abort || !vec_valid) begin
            state_q <= S_DONE;
          end else begin
            {op1_q, op2_q, exp_q, fexp_q} <= vec_data;
            scnt_q  <= '0;
            tmo_q   <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (abort) begin
            state_q <= S_DONE;
          end else if (scnt_q == SW'(START_CYCLES - 1)) begin
            tmr_q   <= '0;
            state_q <= S_WAIT;
          end else begin
            scnt_q <= scnt_q + SW'(1);
          end
        end
        S_WAIT: begin
          if (abort) begin
            state_q <= S_DONE;
          end else if (dut_done) begin
            state_q <= S_CHECK;
          end else if (tmr_q == TW'(TIMEOUT - 1)) begin
            tmo_q   <= 1'b1;
            state_q <= S_CHECK;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        S_CHECK: begin
          // statistics update even when abort lands on this cycle
          vcnt_q <= sat_inc(vcnt_q);
          if (fail) begin
            ecnt_q <= sat_inc(ecnt_q);
            if (!fev_q) begin
              fea_q <= addr_q;
              fev_q <= 1'b1;
            end
          end
          if (tmo_q) tcnt_q <= sat_inc(tcnt_q);
          state_q <= abort ? S_DONE : S_NEXT;
        end
        S_NEXT: begin
          if (abort || (&addr_q)) begin
            state_q <= S_DONE;
          end else begin
            addr_q  <= addr_q + AW'(1);
            state_q <= S_FETCH;
          end
        end
        S_DONE: if (!run) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_vector_checker.sv
// Directed bench for fp_vector_checker: main 64-bit instance plus
// a small AW=2 instance for end-of-address and async reset checks.
module tb_fp_vector_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // main instance
  logic         rst, run, abort_r, cmpf;
  logic [15:0]  vec_addr;
  logic [196:0] vec_data;
  logic         vec_valid;
  logic [63:0]  op1, op2, res;
  logic         dstart, ddone;
  logic [4:0]   dflags;
  logic         busy, fin, mm;
  logic [31:0]  vcnt, ecnt, tcnt;
  logic [15:0]  fea;
  logic         fev;

  logic [63:0] op1_t [16];
  logic [63:0] op2_t [16];
  logic [63:0] exp_t [16];
  logic [63:0] res_t [16];
  logic [4:0]  fexp_t[16];
  logic [4:0]  fres_t[16];
  bit          hang_t[16];
  int          n_valid;
  logic [3:0]  idx;
  logic [7:0]  dcnt = 8'hff;

  fp_vector_checker u_dut (
    .clk(clk), .reset(rst), .run(run), .abort(abort_r),
    .cmp_flags(cmpf), .vec_addr(vec_addr), .vec_data(vec_data),
    .vec_valid(vec_valid), .dut_op1(op1), .dut_op2(op2),
    .dut_start(dstart), .dut_result(res), .dut_flags(dflags),
    .dut_done(ddone), .busy(busy), .finished(fin), .mismatch(mm),
    .vec_count(vcnt), .err_count(ecnt), .tmo_count(tcnt),
    .first_err_addr(fea), .first_err_valid(fev)
  );

  assign idx = vec_addr[3:0];

  always @(posedge clk) begin
    vec_data  <= {op1_t[idx], op2_t[idx], exp_t[idx], fexp_t[idx]};
    vec_valid <= (int'(vec_addr) < n_valid);
  end

  // unit model: done 10 cycles after the start strobe drops
  always @(posedge clk) begin
    if (dstart) dcnt <= 8'd0;
    else if (dcnt != 8'hff) dcnt <= dcnt + 8'd1;
  end
  assign ddone  = !dstart && (dcnt == 8'd9) && !hang_t[idx];
  assign res    = res_t[idx];
  assign dflags = fres_t[idx];

  int   st_hi = 0, st_rise = 0, mm_cnt = 0;
  logic st_prev = 1'b0;
  always @(negedge clk) begin
    if (dstart) st_hi++;
    if (dstart && !st_prev) st_rise++;
    st_prev = dstart;
    if (mm) mm_cnt++;
  end

  // small instance
  logic        rst2, run2;
  logic [1:0]  va2;
  logic [100:0] vd2;
  logic        vv2;
  logic [31:0] o1_2, o2_2, res2;
  logic        ds2, busy2, fin2, mm2, fev2;
  logic [7:0]  vc2, ec2, tc2;
  logic [1:0]  fea2;

  fp_vector_checker #(
    .WIDTH(32), .FLAGW(5), .AW(2),
    .START_CYCLES(2), .TIMEOUT(8), .CW(8)
  ) u_small (
    .clk(clk), .reset(rst2), .run(run2), .abort(1'b0),
    .cmp_flags(1'b1), .vec_addr(va2), .vec_data(vd2),
    .vec_valid(vv2), .dut_op1(o1_2), .dut_op2(o2_2),
    .dut_start(ds2), .dut_result(res2), .dut_flags(5'd0),
    .dut_done(1'b1), .busy(busy2), .finished(fin2), .mismatch(mm2),
    .vec_count(vc2), .err_count(ec2), .tmo_count(tc2),
    .first_err_addr(fea2), .first_err_valid(fev2)
  );

  always @(posedge clk) begin
    vd2 <= '0;
    vv2 <= 1'b1;
  end
  assign res2 = (va2 == 2'd2) ? 32'd1 : 32'd0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_fin(input string tag);
    int n = 0;
    while (!fin && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, fin, 1);
  endtask

  task automatic wait_start(input logic [15:0] a, input string tag);
    int n = 0;
    while (!(dstart && vec_addr == a) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (n < 400), 1);
  endtask

  task automatic stop_pass();
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  int s0, r0, m0, n;

  initial begin
    for (int i = 0; i < 16; i++) begin
      op1_t[i]  = 64'h4000_0000_0000_0000 + 64'(i);
      op2_t[i]  = 64'h3FF0_0000_0000_0000 + 64'(i);
      exp_t[i]  = 64'h3FF0_0000_0000_0000 + 64'(i * 16);
      res_t[i]  = exp_t[i];
      fexp_t[i] = 5'd0;
      fres_t[i] = 5'd0;
      hang_t[i] = 1'b0;
    end
    exp_t[1] = 64'h3FF0_0000_0000_0000;
    res_t[1] = exp_t[1];
    n_valid  = 3;
    rst = 1'b1; run = 1'b0; abort_r = 1'b0; cmpf = 1'b1;
    rst2 = 1'b1; run2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_fin", fin, 0);
    chk("rst_addr", vec_addr, 0);
    chk("rst_start", dstart, 0);
    chk("rst_vcnt", vcnt, 0);
    chk("rst_fev", fev, 0);
    rst = 1'b0; rst2 = 1'b0;
    @(negedge clk);

    // three matching vectors
    s0 = st_hi; r0 = st_rise;
    run = 1'b1;
    wait_fin("t1_fin");
    chk("t1_vcnt", vcnt, 3);
    chk("t1_ecnt", ecnt, 0);
    chk("t1_fev", fev, 0);
    chk("t1_start_cyc", st_hi - s0, 6);
    chk("t1_start_pulses", st_rise - r0, 3);
    chk("t1_busy", busy, 0);
    stop_pass();
    chk("t1_idle", fin, 0);

    // result off by one ulp at addr 1
    res_t[1] = 64'h3FF0_0000_0000_0001;
    m0 = mm_cnt;
    run = 1'b1;
    wait_fin("t2_fin");
    chk("t2_vcnt", vcnt, 3);
    chk("t2_ecnt", ecnt, 1);
    chk("t2_fea", fea, 1);
    chk("t2_fev", fev, 1);
    chk("t2_pulses", mm_cnt - m0, 1);
    chk("t2_tcnt", tcnt, 0);
    stop_pass();
    res_t[1] = exp_t[1];

    // flag-only difference
    fres_t[0] = 5'b00001;
    cmpf = 1'b0;
    run = 1'b1;
    wait_fin("t3a_fin");
    chk("t3a_ecnt", ecnt, 0);
    chk("t3a_fev", fev, 0);
    stop_pass();
    cmpf = 1'b1;
    run = 1'b1;
    wait_fin("t3b_fin");
    chk("t3b_ecnt", ecnt, 1);
    chk("t3b_fea", fea, 0);
    stop_pass();
    fres_t[0] = 5'd0;

    // hang on addr 1
    hang_t[1] = 1'b1;
    run = 1'b1;
    wait_start(16'd1, "t4_start");
    n = 0;
    while (dstart && n < 10) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!mm && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t4_wait_len", n, 64);
    wait_fin("t4_fin");
    chk("t4_tcnt", tcnt, 1);
    chk("t4_ecnt", ecnt, 1);
    chk("t4_vcnt", vcnt, 3);
    chk("t4_fea", fea, 1);
    stop_pass();
    hang_t[1] = 1'b0;

    // abort during WAIT of the third vector
    run = 1'b1;
    wait_start(16'd2, "t5_start");
    n = 0;
    while (dstart && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    abort_r = 1'b1;
    @(negedge clk);
    abort_r = 1'b0;
    chk("t5_fin", fin, 1);
    chk("t5_start", dstart, 0);
    chk("t5_vcnt", vcnt, 2);
    stop_pass();
    chk("t5_idle_fin", fin, 0);
    chk("t5_idle_busy", busy, 0);
    run = 1'b1;
    @(negedge clk);
    chk("t5_clr_vcnt", vcnt, 0);
    chk("t5_busy", busy, 1);
    wait_fin("t5_refin");
    chk("t5_re_vcnt", vcnt, 3);
    stop_pass();

    // AW=2 instance: full table, no wrap
    run2 = 1'b1;
    n = 0;
    while (!fin2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("s_fin", fin2, 1);
    chk("s_vcnt", vc2, 4);
    chk("s_addr", va2, 3);
    chk("s_ecnt", ec2, 1);
    chk("s_fea", fea2, 2);
    run2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    run2 = 1'b1;
    n = 0;
    while (!ds2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("s_in_start", ds2, 1);
    rst2 = 1'b1;
    #1;
    chk("s_rst_start", ds2, 0);
    chk("s_rst_busy", busy2, 0);
    chk("s_rst_fin", fin2, 0);
    chk("s_rst_vcnt", vc2, 0);
    chk("s_rst_addr", va2, 0);
    chk("s_rst_fev", fev2, 0);
    run2 = 1'b0;
    @(negedge clk);
    rst2 = 1'b0;
    @(negedge clk);
    chk("s_idle", busy2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
